// File: rtl/smartcard_conv.sv
// Smart-card (ISO 7816-3) convention converter.
// Watches the TS byte at the start of each ATR to pick direct or inverse
// convention. It then decodes received bytes and parity, encodes transmitted
// bytes, and keeps a saturating count of parity errors.
//
// Ports:
//   baseclk, reset_n          clock (rising edge), async active-low reset
//   restart                   one-cycle pulse, return to HUNT for a new ATR
//   u_rx_data/valid/ready     raw bytes from the UART (lsb-first, H=1)
//   u_par_err                 UART even-parity flag, qualified by u_rx_valid
//   u_tx_data/valid/ready     raw bytes to the UART
//   rx_data/valid/ready       decoded byte stream with rx_par_err
//   tx_data/valid/ready       logical bytes to send
//   conv                      00 HUNT, 01 DIRECT, 11 INVERSE, 10 TS_ERR
//   par_err_cnt               saturating count of corrected parity errors
//
// state    | meaning
// ---------+---------------------------------------------------------------
// HUNT     | waiting for the TS byte; transmit path blocked
// DIRECT   | direct convention; bytes pass through unchanged
// INVERSE  | inverse convention; bytes complemented and bit-reversed
// TS_ERR   | TS was not recognised; rx bytes dropped until restart

module smartcard_conv #(
    parameter int unsigned CNT_BITS   = 16,
    parameter logic [7:0]  TS_DIRECT  = 8'h3B,
    parameter logic [7:0]  TS_INVERSE = 8'h03
) (
    input  logic                baseclk,
    input  logic                reset_n,
    input  logic                restart,
    input  logic [7:0]          u_rx_data,
    input  logic                u_rx_valid,
    output logic                u_rx_ready,
    input  logic                u_par_err,
    output logic [7:0]          u_tx_data,
    output logic                u_tx_valid,
    input  logic                u_tx_ready,
    output logic [7:0]          rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_par_err,
    input  logic [7:0]          tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [1:0]          conv,
    output logic [CNT_BITS-1:0] par_err_cnt
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'b00,
        ST_DIRECT  = 2'b01,
        ST_TS_ERR  = 2'b10,
        ST_INVERSE = 2'b11
    } state_t;

    // Inverse convention: complement every bit and reverse bit order.
    function automatic logic [7:0] inv_map(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = ~b[7-i];
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic                rx_valid_q, rx_valid_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_par_err_q, rx_par_err_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          rst_sync_q;

    logic                rst_ok;
    logic                accept;
    logic                load;
    logic [7:0]          byte_dec;
    logic                perr_dec;
    logic                mode_ok;

    // Reset release is retimed through two flops. No byte is accepted until
    // the second edge after release has passed.
    always_ff @(posedge baseclk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync_q[1];

    // While reset is asserted the UART sees ready high. During the short
    // synchronisation window after release it is held low so no byte is lost.
    assign u_rx_ready = (~rx_valid_q | rx_ready) & (rst_ok | ~reset_n);

    // restart beats a coincident transfer: the offered byte is discarded.
    assign accept = u_rx_valid & u_rx_ready & ~restart;

    always_comb begin
        state_d      = state_q;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        rx_par_err_d = rx_par_err_q;
        cnt_d        = cnt_q;
        load         = 1'b0;
        byte_dec     = 8'h00;
        perr_dec     = 1'b0;

        if (rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                ST_HUNT: begin
                    load = 1'b1;
                    if (u_rx_data == TS_DIRECT) begin
                        state_d  = ST_DIRECT;
                        byte_dec = u_rx_data;
                        perr_dec = u_par_err;
                    end else if (u_rx_data == TS_INVERSE) begin
                        state_d  = ST_INVERSE;
                        byte_dec = inv_map(u_rx_data);
                        perr_dec = ~u_par_err;
                    end else begin
                        state_d  = ST_TS_ERR;
                        byte_dec = u_rx_data;
                        perr_dec = 1'b1;
                    end
                end
                ST_DIRECT: begin
                    load     = 1'b1;
                    byte_dec = u_rx_data;
                    perr_dec = u_par_err;
                end
                ST_INVERSE: begin
                    // Nine complemented bits flip the sense of even parity.
                    load     = 1'b1;
                    byte_dec = inv_map(u_rx_data);
                    perr_dec = ~u_par_err;
                end
                default: begin
                    load = 1'b0;
                end
            endcase
        end

        if (load) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = byte_dec;
            rx_par_err_d = perr_dec;
            if (perr_dec && (cnt_q != {CNT_BITS{1'b1}})) begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end

        if (restart) begin
            state_d    = ST_HUNT;
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge baseclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_par_err_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            rx_par_err_q <= rx_par_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign mode_ok    = (state_q == ST_DIRECT) || (state_q == ST_INVERSE);
    assign u_tx_data  = (state_q == ST_INVERSE) ? inv_map(tx_data) : tx_data;
    assign u_tx_valid = tx_valid & mode_ok;
    assign tx_ready   = u_tx_ready & mode_ok;

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_par_err  = rx_par_err_q;
    assign conv        = state_q;
    assign par_err_cnt = cnt_q;

endmodule

// File: tb/tb_smartcard_conv.sv
module tb_smartcard_conv;

    localparam int CNT_BITS = 4;

    logic                baseclk;
    logic                reset_n;
    logic                restart;
    logic [7:0]          u_rx_data;
    logic                u_rx_valid;
    logic                u_rx_ready;
    logic                u_par_err;
    logic [7:0]          u_tx_data;
    logic                u_tx_valid;
    logic                u_tx_ready;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                rx_par_err;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [1:0]          conv;
    logic [CNT_BITS-1:0] par_err_cnt;

    int n_assert;
    int n_fail;
    int exp_cnt;

    smartcard_conv #(
        .CNT_BITS   (CNT_BITS),
        .TS_DIRECT  (8'h3B),
        .TS_INVERSE (8'h03)
    ) dut (
        .baseclk     (baseclk),
        .reset_n     (reset_n),
        .restart     (restart),
        .u_rx_data   (u_rx_data),
        .u_rx_valid  (u_rx_valid),
        .u_rx_ready  (u_rx_ready),
        .u_par_err   (u_par_err),
        .u_tx_data   (u_tx_data),
        .u_tx_valid  (u_tx_valid),
        .u_tx_ready  (u_tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_par_err  (rx_par_err),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .conv        (conv),
        .par_err_cnt (par_err_cnt)
    );

    initial baseclk = 1'b0;
    always #5 baseclk = ~baseclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge baseclk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b, input logic pe);
        u_rx_data  = b;
        u_par_err  = pe;
        u_rx_valid = 1'b1;
        tick();
        u_rx_valid = 1'b0;
        u_par_err  = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset_n    = 1'b1;
        restart    = 1'b0;
        u_rx_data  = 8'h00;
        u_rx_valid = 1'b0;
        u_par_err  = 1'b0;
        u_tx_ready = 1'b1;
        rx_ready   = 1'b1;
        tx_data    = 8'h3F;
        tx_valid   = 1'b1;

        // Reset state
        #1 reset_n = 1'b0;
        #3;
        chk("rst_conv",       32'(conv), 32'h0);
        chk("rst_u_rx_ready", 32'(u_rx_ready), 32'h1);
        chk("rst_tx_ready",   32'(tx_ready), 32'h0);
        chk("rst_u_tx_valid", 32'(u_tx_valid), 32'h0);
        chk("rst_rx_valid",   32'(rx_valid), 32'h0);
        chk("rst_cnt",        32'(par_err_cnt), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();

        // HUNT -> DIRECT on 3B
        xfer(8'h3B, 1'b0);
        chk("d_conv",   32'(conv), 32'h1);
        chk("d_valid",  32'(rx_valid), 32'h1);
        chk("d_data",   32'(rx_data), 32'h3B);
        chk("d_perr",   32'(rx_par_err), 32'h0);
        chk("d_cnt",    32'(par_err_cnt), 32'h0);
        tx_data = 8'hA5;
        #1;
        chk("d_u_tx_data",  32'(u_tx_data), 32'hA5);
        chk("d_u_tx_valid", 32'(u_tx_valid), 32'h1);
        chk("d_tx_ready",   32'(tx_ready), 32'h1);
        xfer(8'h12, 1'b1);
        chk("d2_data", 32'(rx_data), 32'h12);
        chk("d2_perr", 32'(rx_par_err), 32'h1);
        chk("d2_cnt",  32'(par_err_cnt), 32'h1);
        tick();
        chk("d2_drain", 32'(rx_valid), 32'h0);

        // restart keeps the counter
        pulse_restart();
        chk("rs_conv", 32'(conv), 32'h0);
        chk("rs_cnt",  32'(par_err_cnt), 32'h1);
        chk("rs_tx_ready", 32'(tx_ready), 32'h0);

        // HUNT -> INVERSE
        xfer(8'h03, 1'b1);
        chk("i_conv", 32'(conv), 32'h3);
        chk("i_data", 32'(rx_data), 32'h3F);
        chk("i_perr", 32'(rx_par_err), 32'h0);
        xfer(8'hC0, 1'b1);
        chk("i2_data",  32'(rx_data), 32'hFC);
        chk("i2_perr",  32'(rx_par_err), 32'h0);
        chk("i2_valid", 32'(rx_valid), 32'h1);
        chk("i2_cnt",   32'(par_err_cnt), 32'h1);
        xfer(8'hAA, 1'b0);
        chk("i3_data", 32'(rx_data), 32'hAA);
        chk("i3_perr", 32'(rx_par_err), 32'h1);
        chk("i3_cnt",  32'(par_err_cnt), 32'h2);
        tx_data = 8'h3F;
        #1;
        chk("i_u_tx_data",  32'(u_tx_data), 32'h03);
        chk("i_u_tx_valid", 32'(u_tx_valid), 32'h1);
        tick();

        // restart coincident with a transfer: byte discarded
        restart    = 1'b1;
        u_rx_data  = 8'h3B;
        u_rx_valid = 1'b1;
        tick();
        restart    = 1'b0;
        u_rx_valid = 1'b0;
        chk("rsx_conv",  32'(conv), 32'h0);
        chk("rsx_valid", 32'(rx_valid), 32'h0);
        tick();
        chk("rsx_conv2", 32'(conv), 32'h0);

        // Unknown TS -> TS_ERR
        xfer(8'h55, 1'b0);
        chk("e_conv",  32'(conv), 32'h2);
        chk("e_valid", 32'(rx_valid), 32'h1);
        chk("e_data",  32'(rx_data), 32'h55);
        chk("e_perr",  32'(rx_par_err), 32'h1);
        chk("e_cnt",   32'(par_err_cnt), 32'h3);
        chk("e_tx_ready",   32'(tx_ready), 32'h0);
        chk("e_u_tx_valid", 32'(u_tx_valid), 32'h0);
        xfer(8'h3B, 1'b0);
        chk("e2_valid", 32'(rx_valid), 32'h0);
        chk("e2_conv",  32'(conv), 32'h2);
        pulse_restart();
        xfer(8'h3B, 1'b0);
        chk("e3_conv", 32'(conv), 32'h1);
        tick();

        // Backpressure in DIRECT
        rx_ready = 1'b0;
        xfer(8'h11, 1'b0);
        chk("bp_valid1", 32'(rx_valid), 32'h1);
        chk("bp_data1",  32'(rx_data), 32'h11);
        u_rx_data  = 8'h22;
        u_rx_valid = 1'b1;
        #1;
        chk("bp_stall_rdy", 32'(u_rx_ready), 32'h0);
        tick();
        chk("bp_hold_data", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        #1;
        chk("bp_rdy_again", 32'(u_rx_ready), 32'h1);
        tick();
        u_rx_valid = 1'b0;
        chk("bp_reload_valid", 32'(rx_valid), 32'h1);
        chk("bp_reload_data",  32'(rx_data), 32'h22);
        tick();
        chk("bp_drain", 32'(rx_valid), 32'h0);

        // Counter saturation
        exp_cnt = 3;
        for (int i = 0; i < (1 << CNT_BITS); i++) begin
            xfer(8'(8'h40 + i), 1'b1);
            if (exp_cnt < (1 << CNT_BITS) - 1) exp_cnt++;
            chk("sat_cnt", 32'(par_err_cnt), 32'(exp_cnt));
        end
        chk("sat_final", 32'(par_err_cnt), 32'hF);

        // Reset mid-stream
        u_rx_data  = 8'h77;
        u_par_err  = 1'b1;
        u_rx_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("mr_valid",      32'(rx_valid), 32'h0);
        chk("mr_data",       32'(rx_data), 32'h0);
        chk("mr_perr",       32'(rx_par_err), 32'h0);
        chk("mr_cnt",        32'(par_err_cnt), 32'h0);
        chk("mr_conv",       32'(conv), 32'h0);
        chk("mr_u_rx_ready", 32'(u_rx_ready), 32'h1);
        chk("mr_tx_ready",   32'(tx_ready), 32'h0);
        chk("mr_u_tx_valid", 32'(u_tx_valid), 32'h0);

        // Release with a TS byte already offered: first transfer not before edge 3
        u_rx_data = 8'h3B;
        u_par_err = 1'b0;
        @(negedge baseclk);
        reset_n = 1'b1;
        tick();
        chk("rel_e1_conv", 32'(conv), 32'h0);
        tick();
        chk("rel_e2_conv", 32'(conv), 32'h0);
        tick();
        u_rx_valid = 1'b0;
        chk("rel_e3_conv", 32'(conv), 32'h1);
        chk("rel_e3_data", 32'(rx_data), 32'h3B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
